elastic_register_pipe: RTL and testbench

//  Parametrised successor to the ideal N-bit register: a DEPTH-stage pipeline register with
//  per-stage valid/ready flow control, bubble collapsing, synchronous flush and occupancy count.

---
 rtl/adder_sim_pkg.sv | 17 +
 rtl/pipe_stage.sv | 41 ++++
 rtl/elastic_register_pipe.sv | 94 +++++++++
 tb/tb_elastic_register_pipe.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/adder_sim_pkg.sv
// Shared constants and helpers for the adder simulation pipe blocks.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: MAX_PIPE_DEPTH bound and clog2_cnt(), the width of a 0..depth counter.
package adder_sim_pkg;

  localparam int MAX_PIPE_DEPTH = 16;

  // Bits needed to hold any value 0..depth inclusive (at least 1).
  function automatic int clog2_cnt(input int depth);
    int w;
    w = 1;
    while ((1 << w) < (depth + 1)) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// One valid/data register pair of the elastic pipe.
// Latency: 1 cycle from up_valid/up_data to valid_q/data_q when rdy is high.
// Backpressure: holds its contents whenever rdy is low; flush clears valid only.
// Ports: clk, rst (async, active high), flush, rdy (stage may load this edge),
//        up_valid/up_data (previous stage or pipe input), valid_q/data_q (stage contents).
module pipe_stage #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         rdy,
  input  logic         up_valid,
  input  logic [N-1:0] up_data,
  output logic         valid_q,
  output logic [N-1:0] data_q
);

  logic         r_valid;
  logic [N-1:0] r_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (flush) begin
      // Data is left alone on flush; only the valid bit matters downstream.
      r_valid <= 1'b0;
    end else if (rdy) begin
      r_valid <= up_valid;
      // Bubbles move the valid bit only, so the data register does not toggle.
      if (up_valid) begin
        r_data <= up_data;
      end
    end
  end

  assign valid_q = r_valid;
  assign data_q  = r_data;

endmodule

// File: rtl/elastic_register_pipe.sv
// DEPTH-stage valid/ready register pipe with bubble collapsing, flush and occupancy count.
// Latency: DEPTH cycles from accept to out when unstalled; 1 word/cycle throughput.
// Backpressure: combinational ready chain; in_ready low only when every stage is full and
//   out_ready is low, or during flush/rst.
// Ports: clk, rst (async, active high), flush, in_valid/in_ready/in (upstream),
//        out_valid/out_ready/out (downstream), count (valid stages, 0..DEPTH).
module elastic_register_pipe
  import adder_sim_pkg::*;
#(
  parameter int N = 8,
  parameter int DEPTH = 2,
  localparam int CW = clog2_cnt(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out,
  output logic [CW-1:0] count
);

  if (DEPTH < 1 || DEPTH > MAX_PIPE_DEPTH) begin : g_bad_depth
    $error("elastic_register_pipe: DEPTH=%0d outside 1..%0d", DEPTH, MAX_PIPE_DEPTH);
  end

  logic [DEPTH:0]   w_rdy;
  logic [DEPTH-1:0] w_vld;
  logic [N-1:0]     w_dat [DEPTH];
  logic [DEPTH-1:0] w_up_vld;
  logic [N-1:0]     w_up_dat [DEPTH];
  logic [DEPTH-1:0] w_vld_nxt;
  logic [CW-1:0]    w_count_nxt;
  logic [CW-1:0]    r_count;

  assign w_rdy[DEPTH] = out_ready;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    // A stage can load if it is empty or its contents move on this edge.
    assign w_rdy[i] = ~w_vld[i] | w_rdy[i+1];

    if (i == 0) begin : g_head
      assign w_up_vld[i] = in_valid;
      assign w_up_dat[i] = in;
    end else begin : g_body
      assign w_up_vld[i] = w_vld[i-1];
      assign w_up_dat[i] = w_dat[i-1];
    end

    pipe_stage #(.N(N)) u_stage (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .rdy      (w_rdy[i]),
      .up_valid (w_up_vld[i]),
      .up_data  (w_up_dat[i]),
      .valid_q  (w_vld[i]),
      .data_q   (w_dat[i])
    );
  end

  // Mirror of the stage update rule, used only to register the popcount alongside the stages.
  always_comb begin
    w_vld_nxt   = '0;
    w_count_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (flush) begin
        w_vld_nxt[i] = 1'b0;
      end else if (w_rdy[i]) begin
        w_vld_nxt[i] = w_up_vld[i];
      end else begin
        w_vld_nxt[i] = w_vld[i];
      end
      w_count_nxt = w_count_nxt + CW'(w_vld_nxt[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_nxt;
    end
  end

  assign in_ready  = w_rdy[0] & ~flush & ~rst;
  assign out_valid = w_vld[DEPTH-1] & ~flush;
  assign out       = w_dat[DEPTH-1];
  assign count     = r_count;

endmodule

// File: tb/tb_elastic_register_pipe.sv
// Directed and randomized checks of elastic_register_pipe at DEPTH=3 (N=8), DEPTH=1 and 4 (N=16).
module tb_elastic_register_pipe;

  logic clk;
  logic rst;

  // DEPTH=3, N=8
  logic       a_flush, a_ivld, a_irdy, a_ovld, a_ordy;
  logic [7:0] a_in, a_out;
  logic [1:0] a_cnt;

  // DEPTH=1, N=16
  logic        b_ivld, b_irdy, b_ovld, b_ordy;
  logic [15:0] b_in, b_out;
  logic [0:0]  b_cnt;

  // DEPTH=4, N=16
  logic        c_ivld, c_irdy, c_ovld, c_ordy;
  logic [15:0] c_in, c_out;
  logic [2:0]  c_cnt;

  logic [15:0] qb[$];
  logic [15:0] qc[$];
  logic        exp_rdy;

  int n_cmp;
  int n_err;

  elastic_register_pipe #(.N(8), .DEPTH(3)) u_a (
    .clk(clk), .rst(rst), .flush(a_flush),
    .in_valid(a_ivld), .in_ready(a_irdy), .in(a_in),
    .out_valid(a_ovld), .out_ready(a_ordy), .out(a_out), .count(a_cnt)
  );

  elastic_register_pipe #(.N(16), .DEPTH(1)) u_b (
    .clk(clk), .rst(rst), .flush(1'b0),
    .in_valid(b_ivld), .in_ready(b_irdy), .in(b_in),
    .out_valid(b_ovld), .out_ready(b_ordy), .out(b_out), .count(b_cnt)
  );

  elastic_register_pipe #(.N(16), .DEPTH(4)) u_c (
    .clk(clk), .rst(rst), .flush(1'b0),
    .in_valid(c_ivld), .in_ready(c_irdy), .in(c_in),
    .out_valid(c_ovld), .out_ready(c_ordy), .out(c_out), .count(c_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst = 1'b1;
    a_flush = 1'b0; a_ivld = 1'b0; a_ordy = 1'b0; a_in = '0;
    b_ivld = 1'b0; b_ordy = 1'b0; b_in = '0;
    c_ivld = 1'b0; c_ordy = 1'b0; c_in = '0;

    // Reset state
    #1;
    chk("rst_ovld", 32'(a_ovld), 0);
    chk("rst_out",  32'(a_out),  0);
    chk("rst_cnt",  32'(a_cnt),  0);
    chk("rst_irdy", 32'(a_irdy), 0);
    chk("rst_b_out", 32'(b_out), 0);
    chk("rst_c_cnt", 32'(c_cnt), 0);
    @(negedge clk); rst = 1'b0;
    #1 chk("rel_irdy", 32'(a_irdy), 1);

    // Streaming 0x11,0x22,0x33 with out_ready high
    @(negedge clk); a_ordy = 1'b1; a_ivld = 1'b1; a_in = 8'h11;
    #1 chk("s_irdy0", 32'(a_irdy), 1); chk("s_cnt0", 32'(a_cnt), 0);
    @(negedge clk); a_in = 8'h22;
    #1 chk("s_cnt1", 32'(a_cnt), 1); chk("s_ovld1", 32'(a_ovld), 0);
    @(negedge clk); a_in = 8'h33;
    #1 chk("s_cnt2", 32'(a_cnt), 2); chk("s_ovld2", 32'(a_ovld), 0);
    @(negedge clk); a_ivld = 1'b0;
    #1 chk("s_ovld3", 32'(a_ovld), 1); chk("s_out3", 32'(a_out), 32'h11); chk("s_cnt3", 32'(a_cnt), 3);
    @(negedge clk);
    #1 chk("s_out4", 32'(a_out), 32'h22); chk("s_cnt4", 32'(a_cnt), 2);
    @(negedge clk);
    #1 chk("s_out5", 32'(a_out), 32'h33); chk("s_cnt5", 32'(a_cnt), 1);
    @(negedge clk);
    #1 chk("s_ovld6", 32'(a_ovld), 0); chk("s_cnt6", 32'(a_cnt), 0);

    // Stalled fill with a bubble: bubble collapses
    @(negedge clk); a_ordy = 1'b0; a_ivld = 1'b1; a_in = 8'hA1;
    #1 chk("b_irdy0", 32'(a_irdy), 1);
    @(negedge clk); a_ivld = 1'b0;
    #1 chk("b_cnt1", 32'(a_cnt), 1);
    @(negedge clk); a_ivld = 1'b1; a_in = 8'hA2;
    #1 chk("b_cnt2", 32'(a_cnt), 1); chk("b_ovld2", 32'(a_ovld), 0);
    @(negedge clk); a_in = 8'hA3;
    #1 chk("b_cnt3", 32'(a_cnt), 2); chk("b_out3", 32'(a_out), 32'hA1); chk("b_irdy3", 32'(a_irdy), 1);
    @(negedge clk); a_in = 8'hA4;
    #1 chk("b_cnt4", 32'(a_cnt), 3); chk("b_irdy4", 32'(a_irdy), 0); chk("b_out4", 32'(a_out), 32'hA1);
    @(negedge clk); a_ivld = 1'b0;
    #1 chk("b_cnt5", 32'(a_cnt), 3); chk("b_out5", 32'(a_out), 32'hA1); chk("b_ovld5", 32'(a_ovld), 1);
    @(negedge clk); a_ordy = 1'b1;
    #1 chk("b_out6", 32'(a_out), 32'hA1); chk("b_irdy6", 32'(a_irdy), 1);
    @(negedge clk);
    #1 chk("b_out7", 32'(a_out), 32'hA2); chk("b_cnt7", 32'(a_cnt), 2);
    @(negedge clk);
    #1 chk("b_out8", 32'(a_out), 32'hA3); chk("b_cnt8", 32'(a_cnt), 1);
    @(negedge clk);
    #1 chk("b_ovld9", 32'(a_ovld), 0); chk("b_cnt9", 32'(a_cnt), 0);

    // Full pipe: accept and emit on the same edge
    @(negedge clk); a_ordy = 1'b0; a_ivld = 1'b1; a_in = 8'hB1;
    #1 chk("f_irdy_empty", 32'(a_irdy), 1);
    @(negedge clk); a_in = 8'hB2;
    @(negedge clk); a_in = 8'hB3;
    @(negedge clk); a_in = 8'hB4;
    #1 chk("f_cnt", 32'(a_cnt), 3); chk("f_irdy_stall", 32'(a_irdy), 0); chk("f_out", 32'(a_out), 32'hB1);
    a_ordy = 1'b1;
    #1 chk("f_irdy_go", 32'(a_irdy), 1);
    @(negedge clk); a_ivld = 1'b0;
    #1 chk("f_cnt_after", 32'(a_cnt), 3); chk("f_out_after", 32'(a_out), 32'hB2);

    // Flush with two valid words and an offered word
    @(negedge clk); a_flush = 1'b1; a_ivld = 1'b1; a_in = 8'hC1;
    #1 chk("fl_cnt", 32'(a_cnt), 2); chk("fl_irdy", 32'(a_irdy), 0); chk("fl_ovld", 32'(a_ovld), 0);
    @(negedge clk); a_flush = 1'b0; a_ivld = 1'b0;
    #1 chk("fl_cnt_after", 32'(a_cnt), 0); chk("fl_ovld_after", 32'(a_ovld), 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1 chk("fl_ovld_idle", 32'(a_ovld), 0);
    end

    // Async reset with three words in flight
    @(negedge clk); a_ordy = 1'b0; a_ivld = 1'b1; a_in = 8'hD1;
    @(negedge clk); a_in = 8'hD2;
    @(negedge clk); a_in = 8'hD3;
    @(negedge clk); a_ivld = 1'b0;
    #1 chk("r_cnt_pre", 32'(a_cnt), 3); chk("r_out_pre", 32'(a_out), 32'hD1);
    rst = 1'b1;
    #1 chk("r_ovld", 32'(a_ovld), 0); chk("r_out", 32'(a_out), 0);
    chk("r_cnt", 32'(a_cnt), 0); chk("r_irdy", 32'(a_irdy), 0);
    @(negedge clk); rst = 1'b0; a_ordy = 1'b1;
    #1 chk("r_irdy_rel", 32'(a_irdy), 1); chk("r_ovld_rel", 32'(a_ovld), 0);
    @(negedge clk);
    #1 chk("r_ovld_next", 32'(a_ovld), 0); chk("r_cnt_next", 32'(a_cnt), 0);

    // Random traffic on DEPTH=1 and DEPTH=4 against queue scoreboards
    for (int cyc = 0; cyc < 10000; cyc++) begin
      @(negedge clk);
      b_ivld = 1'($urandom_range(0, 1)); b_ordy = 1'($urandom_range(0, 1)); b_in = 16'($urandom);
      c_ivld = 1'($urandom_range(0, 1)); c_ordy = 1'($urandom_range(0, 1)); c_in = 16'($urandom);
      #1;
      exp_rdy = (qb.size() < 1) || b_ordy;
      chk("rb_irdy", 32'(b_irdy), 32'(exp_rdy));
      chk("rb_cnt", 32'(b_cnt), qb.size());
      if (qb.size() == 1) chk("rb_ovld_full", 32'(b_ovld), 1);
      if (b_ovld) begin
        chk("rb_ovld_nonempty", 32'(qb.size() != 0), 1);
        if (qb.size() != 0) begin
          chk("rb_out", 32'(b_out), 32'(qb[0]));
          if (b_ordy) void'(qb.pop_front());
        end
      end
      if (b_ivld && exp_rdy) qb.push_back(b_in);

      exp_rdy = (qc.size() < 4) || c_ordy;
      chk("rc_irdy", 32'(c_irdy), 32'(exp_rdy));
      chk("rc_cnt", 32'(c_cnt), qc.size());
      if (qc.size() == 4) chk("rc_ovld_full", 32'(c_ovld), 1);
      if (c_ovld) begin
        chk("rc_ovld_nonempty", 32'(qc.size() != 0), 1);
        if (qc.size() != 0) begin
          chk("rc_out", 32'(c_out), 32'(qc[0]));
          if (c_ordy) void'(qc.pop_front());
        end
      end
      if (c_ivld && exp_rdy) qc.push_back(c_in);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
